// File: rtl/button_pkg.sv
// Shared definitions for the button bank: debounce FSM state encoding and width helpers.
package button_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Bits needed to hold values 0..v (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned v);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v + 32'd1) w = i + 1;
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_chan.sv
// One debounced button channel: 2-flop synchroniser, IDLE/ARM/HELD/REL FSM, press strobe.
// Optional auto-repeat timer under BUTTON_BANK_REPEAT_EN.
module button_chan
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_chan: parameter out of range");
    end

    logic          s1, s2;
    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          press;
    logic          rpt_fire;

    // The sample that leaves IDLE/HELD is the first stable one, so the
    // counting states need DEBOUNCE_CYCLES-1 further samples.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press    = 1'b0;
        cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        case (state)
            ST_IDLE: if (s2) begin
                state_nx = SINGLE ? ST_HELD : ST_ARM;
                press    = SINGLE;
                cnt_nx   = '0;
            end
            ST_ARM: if (!s2) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end else if (cnt_inc == CNT_LAST) begin
                state_nx = ST_HELD;
                press    = 1'b1;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt_inc;
            end
            ST_HELD: if (!s2) begin
                state_nx = SINGLE ? ST_IDLE : ST_REL;
                cnt_nx   = '0;
            end
            default: if (s2) begin
                state_nx = ST_HELD;
                cnt_nx   = '0;
            end else if (cnt_inc == CNT_LAST) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= (state_nx == ST_HELD) || (state_nx == ST_REL);
            pulse <= press | rpt_fire;
        end
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RW-1:0] rpt_cnt, rpt_target;
    logic          rpt_first, rpt_roll, rpt_run;

    assign rpt_run    = (state == ST_HELD) || (state == ST_REL);
    assign rpt_target = rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    assign rpt_roll   = rpt_run && (rpt_cnt + RW'(1) == rpt_target);
    // Timer keeps running through REL bounces; strobes only while staying HELD.
    assign rpt_fire   = rpt_roll && (state == ST_HELD) && (state_nx == ST_HELD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (press || state_nx == ST_IDLE) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_roll) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_run) begin
            rpt_cnt   <= rpt_cnt + RW'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// Bank of N_BTN debounced buttons with a lowest-index press encoder.
// Auto-repeat is enabled by defining BUTTON_BANK_REPEAT_EN.
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] pulse,
    output logic             id_valid,
    output logic [3:0]       btn_id,
    output logic             multi
);

    if (N_BTN < 1 || N_BTN > 16) begin : g_width_check
        $error("button_bank: N_BTN out of range");
    end

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[g]),
            .level (level[g]),
            .pulse (pulse[g])
        );
    end

    always_comb begin
        id_valid = 1'b0;
        btn_id   = '0;
        multi    = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (pulse[i]) begin
                if (id_valid) multi = 1'b1;
                else          btn_id = 4'(i);
                id_valid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: vector table plus reset/repeat sequences, pulse scoreboard.
module tb_button_bank;

    localparam int unsigned NB   = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 50;
    localparam int unsigned RPER = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] level;
    logic [NB-1:0] pulse;
    logic          id_valid;
    logic [3:0]    btn_id;
    logic          multi;

    always #5 clk = ~clk;

    button_bank #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .level    (level),
        .pulse    (pulse),
        .id_valid (id_valid),
        .btn_id   (btn_id),
        .multi    (multi)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  pulse;
        logic [3:0]  id;
        logic        multi;
    } exp_t;

    typedef struct {
        logic [3:0]  btn;
        int unsigned hold;
        logic [3:0]  exp_pulse;
        logic [3:0]  exp_id;
        logic        exp_multi;
        logic [3:0]  exp_level;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[6];
    int unsigned cyc;
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned at, input logic [3:0] p, input logic [3:0] id, input logic m);
        exp_t e;
        e.cyc   = at;
        e.pulse = p;
        e.id    = id;
        e.multi = m;
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missed pulse", 32'(pulse), 32'(e.pulse));
        end
        if (pulse != '0) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("pulse", 32'(pulse), 32'(e.pulse));
                check("btn_id", 32'(btn_id), 32'(e.id));
                check("id_valid", 32'(id_valid), 32'd1);
                check("multi", 32'(multi), 32'(e.multi));
            end else begin
                check("unexpected pulse", 32'(pulse), 32'd0);
            end
        end else begin
            check("idle encoder", {28'd0, id_valid, multi, btn_id}, 32'd0);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            monitor();
        end
    endtask

    initial begin
        vecs[0] = '{4'b0100, 20, 4'b0100, 4'd2, 1'b0, 4'b0100};
        vecs[1] = '{4'b0010,  3, 4'b0000, 4'd0, 1'b0, 4'b0000};
        vecs[2] = '{4'b1010, 12, 4'b1010, 4'd1, 1'b1, 4'b1010};
        vecs[3] = '{4'b1000,  4, 4'b1000, 4'd3, 1'b0, 4'b0000};
        vecs[4] = '{4'b0001, 10, 4'b0001, 4'd0, 1'b0, 4'b0001};
        vecs[5] = '{4'b0110,  1, 4'b0000, 4'd0, 1'b0, 4'b0000};

        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        btn   = 4'b1111;

        // Reset held with all buttons pressed.
        repeat (2) begin
            tick(1);
            check("reset outputs", {19'd0, level, pulse, id_valid, btn_id, multi}, 32'd0);
        end
        rst = 1'b1;
        expect_at(cyc + 2 + DEB, 4'b1111, 4'd0, 1'b1);
        tick(10);
        check("level after reset press", 32'(level), 32'hF);
        btn = '0;
        tick(14);
        check("level after release", 32'(level), 32'h0);

        for (int i = 0; i < 6; i++) begin
            btn = vecs[i].btn;
            if (vecs[i].exp_pulse != '0)
                expect_at(cyc + 2 + DEB, vecs[i].exp_pulse, vecs[i].exp_id, vecs[i].exp_multi);
            tick(vecs[i].hold);
            check($sformatf("vec%0d level held", i), 32'(level), 32'(vecs[i].exp_level));
            btn = '0;
            tick(14);
            check($sformatf("vec%0d level released", i), 32'(level), 32'h0);
        end

        // Reset pulse while btn[3] is held: level drops at once, then re-debounces.
        btn = 4'b1000;
        expect_at(cyc + 2 + DEB, 4'b1000, 4'd3, 1'b0);
        tick(10);
        check("level held before reset", 32'(level), 32'h8);
        rst = 1'b0;
        #1;
        check("async reset level", {24'd0, level, pulse}, 32'd0);
        tick(1);
        rst = 1'b1;
        expect_at(cyc + 2 + DEB, 4'b1000, 4'd3, 1'b0);
        tick(10);
        check("level after re-debounce", 32'(level), 32'h8);
        btn = '0;
        tick(14);

        // Long hold of btn[0]: repeat strobes only when the feature is built in.
        btn = 4'b0001;
        begin
            int unsigned t0;
            t0 = cyc + 2 + DEB;
            expect_at(t0, 4'b0001, 4'd0, 1'b0);
`ifdef BUTTON_BANK_REPEAT_EN
            for (int unsigned j = 0; j < 5; j++)
                expect_at(t0 + RDLY + j * RPER, 4'b0001, 4'd0, 1'b0);
`endif
        end
        tick(100);
        check("level long hold", 32'(level), 32'h1);
        btn = '0;
        tick(14);
        check("level after long hold", 32'(level), 32'h0);

        tick(4);
        check("pending expected pulses", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
